// File: rtl/reflet_mem_map_pkg.sv
// Shared types and parameter-field helpers for the Reflet memory-map controller.
package reflet_mem_map_pkg;

  localparam int unsigned max_regions  = 8;
  localparam int unsigned max_wordsize = 64;
  localparam int unsigned word_vec_w   = max_regions * max_wordsize;
  localparam int unsigned wait_vec_w   = max_regions * 4;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  // Width of a region index; a single region still needs one bit.
  function automatic int unsigned index_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Extract word idx of width ws from a packed per-region vector.
  function automatic logic [max_wordsize-1:0] word_field(
    input logic [word_vec_w-1:0] vec,
    input int unsigned           ws,
    input int unsigned           idx
  );
    logic [word_vec_w-1:0]   shifted;
    logic [max_wordsize-1:0] mask;
    shifted = vec >> (idx * ws);
    mask    = (ws >= max_wordsize) ? '1
            : ((max_wordsize'(1) << ws) - max_wordsize'(1));
    return shifted[max_wordsize-1:0] & mask;
  endfunction

  function automatic logic [max_wordsize-1:0] region_base_at(
    input logic [word_vec_w-1:0] vec,
    input int unsigned           ws,
    input int unsigned           idx
  );
    return word_field(vec, ws, idx);
  endfunction

  function automatic logic [max_wordsize-1:0] region_size_at(
    input logic [word_vec_w-1:0] vec,
    input int unsigned           ws,
    input int unsigned           idx
  );
    return word_field(vec, ws, idx);
  endfunction

  function automatic logic [3:0] region_wait_at(
    input logic [wait_vec_w-1:0] vec,
    input int unsigned           idx
  );
    logic [wait_vec_w-1:0] shifted;
    shifted = vec >> (idx * 4);
    return shifted[3:0];
  endfunction

endpackage

// File: rtl/reflet_mem_map_ctrl_if.sv
// CPU-side and region-side bus bundle of the memory-map controller.
interface reflet_mem_map_ctrl_if #(
  parameter int unsigned wordsize     = 8,
  parameter int unsigned region_count = 3
);
  logic [wordsize-1:0]              cpu_addr;
  logic [wordsize-1:0]              cpu_data_out;
  logic                             cpu_write_en;
  logic [wordsize-1:0]              cpu_data_in;
  logic                             cpu_enable;
  logic                             cpu_reset;
  logic [region_count-1:0]          region_enable;
  logic [wordsize-1:0]              region_addr;
  logic [region_count-1:0]          region_write_en;
  logic [wordsize-1:0]              region_data_out;
  logic [region_count*wordsize-1:0] region_data_in;
  logic                             bus_error;
  logic                             bus_error_flag;

  modport slave (
    input  cpu_addr, cpu_data_out, cpu_write_en, region_data_in,
    output cpu_data_in, cpu_enable, cpu_reset, region_enable, region_addr,
           region_write_en, region_data_out, bus_error, bus_error_flag
  );

  modport master (
    output cpu_addr, cpu_data_out, cpu_write_en, region_data_in,
    input  cpu_data_in, cpu_enable, cpu_reset, region_enable, region_addr,
           region_write_en, region_data_out, bus_error, bus_error_flag
  );
endinterface

// File: rtl/reflet_region_decoder.sv
// Address-to-region decoder: lowest-index hit wins, local address relative to its base.
module reflet_region_decoder
  import reflet_mem_map_pkg::*;
#(
  parameter int unsigned                      wordsize     = 8,
  parameter int unsigned                      region_count = 3,
  parameter logic [region_count*wordsize-1:0] region_base  = 24'hEDC000,
  parameter logic [region_count*wordsize-1:0] region_size  = 24'h132C80
) (
  input  logic [wordsize-1:0]                           addr,
  output logic                                          hit,
  output logic [region_count-1:0]                       onehot,
  output logic [index_width(region_count)-1:0]          index,
  output logic [wordsize-1:0]                           local_addr
);
  localparam int unsigned idx_w = index_width(region_count);

  logic [wordsize-1:0] base_w;
  logic [wordsize-1:0] size_w;
  logic [wordsize:0]   end_w;
  logic                in_range;

  // Range compare per region; end computed one bit wider so a region may end at the top.
  always_comb begin
    hit        = 1'b0;
    onehot     = '0;
    index      = '0;
    local_addr = addr;
    base_w     = '0;
    size_w     = '0;
    end_w      = '0;
    in_range   = 1'b0;
    for (int unsigned i = 0; i < region_count; i++) begin
      base_w   = wordsize'(region_base_at(word_vec_w'(region_base), wordsize, i));
      size_w   = wordsize'(region_size_at(word_vec_w'(region_size), wordsize, i));
      end_w    = {1'b0, base_w} + {1'b0, size_w};
      in_range = (size_w != '0) && (addr >= base_w) && ({1'b0, addr} < end_w);
      if (in_range && !hit) begin
        hit        = 1'b1;
        onehot     = region_count'(1) << i;
        index      = idx_w'(i);
        local_addr = addr - base_w;
      end
    end
  end

endmodule

// File: rtl/reflet_mem_map_ctrl.sv
// Memory-map controller: region decode, wait-state stalls, boot hold and unmapped-access flag.
module reflet_mem_map_ctrl
  import reflet_mem_map_pkg::*;
#(
  parameter int unsigned                      wordsize     = 8,
  parameter int unsigned                      region_count = 3,
  parameter logic [region_count*wordsize-1:0] region_base  = 24'hEDC000,
  parameter logic [region_count*wordsize-1:0] region_size  = 24'h132C80,
  parameter logic [region_count*4-1:0]        region_wait  = 12'h010,
  parameter int unsigned                      boot_cycles  = 16
) (
  input logic                 clk,
  input logic                 reset,
  reflet_mem_map_ctrl_if.slave bus
);
  localparam int unsigned idx_w = index_width(region_count);

  state_t                  state, state_next;
  logic [7:0]              cnt, cnt_next;
  logic [idx_w-1:0]        held_idx, held_idx_next;
  logic                    bus_error_q, bus_error_flag_q;

  logic                    dec_hit;
  logic [region_count-1:0] dec_onehot;
  logic [idx_w-1:0]        dec_index;
  logic [wordsize-1:0]     dec_local_addr;
  logic [3:0]              hit_wait;

  logic                    enable_c;
  logic                    err_c;
  logic                    sel_valid;
  logic [idx_w-1:0]        sel_idx;
  logic [region_count-1:0] region_enable_c;

  reflet_region_decoder #(
    .wordsize     (wordsize),
    .region_count (region_count),
    .region_base  (region_base),
    .region_size  (region_size)
  ) u_decoder (
    .addr       (bus.cpu_addr),
    .hit        (dec_hit),
    .onehot     (dec_onehot),
    .index      (dec_index),
    .local_addr (dec_local_addr)
  );

  assign hit_wait = region_wait_at(wait_vec_w'(region_wait), 32'(dec_index));

  // State, shared boot/wait counter, latched region and error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_BOOT;
      cnt              <= 8'(boot_cycles);
      held_idx         <= '0;
      bus_error_q      <= 1'b0;
      bus_error_flag_q <= 1'b0;
    end else begin
      state            <= state_next;
      cnt              <= cnt_next;
      held_idx         <= held_idx_next;
      bus_error_q      <= err_c;
      bus_error_flag_q <= bus_error_flag_q | err_c;
    end
  end

  // Next state, stall control and region selection.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    held_idx_next   = held_idx;
    enable_c        = 1'b0;
    err_c           = 1'b0;
    sel_valid       = 1'b0;
    sel_idx         = held_idx;
    region_enable_c = '0;
    case (state)
      ST_BOOT: begin
        cnt_next = cnt - 8'd1;
        if (cnt <= 8'd1) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        region_enable_c = dec_onehot;
        sel_valid       = dec_hit;
        sel_idx         = dec_index;
        if (!dec_hit) begin
          enable_c = 1'b1;
          err_c    = 1'b1;
        end else if (hit_wait == 4'd0) begin
          enable_c = 1'b1;
        end else begin
          cnt_next      = 8'(hit_wait) - 8'd1;
          held_idx_next = dec_index;
          state_next    = (hit_wait > 4'd1) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        region_enable_c = region_count'(1) << held_idx;
        sel_valid       = 1'b1;
        cnt_next        = cnt - 8'd1;
        if (cnt <= 8'd1) state_next = ST_ACK;
      end
      ST_ACK: begin
        region_enable_c = region_count'(1) << held_idx;
        sel_valid       = 1'b1;
        enable_c        = 1'b1;
        state_next      = ST_IDLE;
      end
      default: state_next = ST_BOOT;
    endcase
  end

  assign bus.cpu_enable      = enable_c;
  assign bus.cpu_reset       = (state == ST_BOOT);
  assign bus.region_enable   = region_enable_c;
  assign bus.region_write_en = region_enable_c & {region_count{bus.cpu_write_en & enable_c}};
  assign bus.region_addr     = dec_local_addr;
  assign bus.region_data_out = bus.cpu_data_out;
  assign bus.cpu_data_in     = sel_valid
                             ? wordsize'(bus.region_data_in >> (32'(sel_idx) * wordsize))
                             : '0;
  assign bus.bus_error       = bus_error_q;
  assign bus.bus_error_flag  = bus_error_flag_q;

endmodule

// File: tb/tb_reflet_mem_map_ctrl.sv
// Directed bench for reflet_mem_map_ctrl: three instances with different region maps.
module tb_reflet_mem_map_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic reset_b;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  reflet_mem_map_ctrl_if #(.wordsize(8), .region_count(3)) bus_a ();
  reflet_mem_map_ctrl_if #(.wordsize(8), .region_count(3)) bus_b ();
  reflet_mem_map_ctrl_if #(.wordsize(8), .region_count(3)) bus_c ();

  // Reference map: {0x00/0x80 w0, 0xC0/0x2C w1, 0xED/0x13 w0}
  reflet_mem_map_ctrl #(
    .wordsize(8), .region_count(3), .region_base(24'hEDC000),
    .region_size(24'h132C80), .region_wait(12'h010), .boot_cycles(4)
  ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  // Same map, region1 with 3 wait states
  reflet_mem_map_ctrl #(
    .wordsize(8), .region_count(3), .region_base(24'hEDC000),
    .region_size(24'h132C80), .region_wait(12'h030), .boot_cycles(4)
  ) dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

  // Overlap map: region0 0xF0/0x10, region1 0xF8/0x08, region2 disabled
  reflet_mem_map_ctrl #(
    .wordsize(8), .region_count(3), .region_base(24'h00F8F0),
    .region_size(24'h000810), .region_wait(12'h000), .boot_cycles(4)
  ) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int stall;
    int wr_pulses;
    int en_in_boot;

    reset   = 1'b1;
    reset_b = 1'b1;
    bus_a.cpu_addr = 8'h10; bus_a.cpu_data_out = 8'h00; bus_a.cpu_write_en = 1'b1;
    bus_a.region_data_in = 24'h3322A5;
    bus_b.cpu_addr = 8'h00; bus_b.cpu_data_out = 8'h00; bus_b.cpu_write_en = 1'b0;
    bus_b.region_data_in = 24'h3322A5;
    bus_c.cpu_addr = 8'h00; bus_c.cpu_data_out = 8'h00; bus_c.cpu_write_en = 1'b0;
    bus_c.region_data_in = 24'h665544;
    repeat (3) tick();

    // Reset state
    check_eq("rst_cpu_reset",  64'(bus_a.cpu_reset),       64'd1);
    check_eq("rst_cpu_enable", 64'(bus_a.cpu_enable),      64'd0);
    check_eq("rst_region_en",  64'(bus_a.region_enable),   64'd0);
    check_eq("rst_write_en",   64'(bus_a.region_write_en), 64'd0);
    check_eq("rst_bus_error",  64'(bus_a.bus_error),       64'd0);
    check_eq("rst_err_flag",   64'(bus_a.bus_error_flag),  64'd0);
    check_eq("rst_data_in",    64'(bus_a.cpu_data_in),     64'd0);
    bus_a.cpu_write_en = 1'b0;

    // Boot hold after reset release
    reset   = 1'b0;
    reset_b = 1'b0;
    n = 0;
    en_in_boot = 0;
    while (bus_a.cpu_reset && n < 50) begin
      if (bus_a.cpu_enable) en_in_boot++;
      tick();
      n++;
    end
    check_eq("boot_len",     64'(n),                64'd4);
    check_eq("boot_en_low",  64'(en_in_boot),       64'd0);
    check_eq("boot_en_rise", 64'(bus_a.cpu_enable), 64'd1);

    // Zero-wait read from region0
    check_eq("zw_region_en", 64'(bus_a.region_enable), 64'h1);
    check_eq("zw_addr",      64'(bus_a.region_addr),   64'h10);
    check_eq("zw_data",      64'(bus_a.cpu_data_in),   64'hA5);
    stall = 0;
    repeat (3) begin
      tick();
      if (!bus_a.cpu_enable) stall++;
    end
    check_eq("zw_no_stall", 64'(stall), 64'd0);

    // Zero-wait write strobes immediately
    bus_a.cpu_addr = 8'h20; bus_a.cpu_data_out = 8'h3C; bus_a.cpu_write_en = 1'b1;
    #1;
    check_eq("zw_wr_strobe", 64'(bus_a.region_write_en), 64'h1);
    check_eq("zw_wr_data",   64'(bus_a.region_data_out), 64'h3C);
    bus_a.cpu_write_en = 1'b0;

    // One-wait read from region1
    bus_a.cpu_addr = 8'hC5;
    #1;
    check_eq("w1_region_en", 64'(bus_a.region_enable), 64'h2);
    check_eq("w1_addr",      64'(bus_a.region_addr),   64'h05);
    check_eq("w1_stall",     64'(bus_a.cpu_enable),    64'd0);
    tick();
    check_eq("w1_ack_en",    64'(bus_a.cpu_enable),    64'd1);
    check_eq("w1_ack_data",  64'(bus_a.cpu_data_in),   64'h22);

    // Top-of-space region2 (0xED + 0x13 = 0x100)
    bus_a.cpu_addr = 8'hFF;
    tick();
    check_eq("top_region_en", 64'(bus_a.region_enable), 64'h4);
    check_eq("top_addr",      64'(bus_a.region_addr),   64'h12);
    check_eq("top_data",      64'(bus_a.cpu_data_in),   64'h33);
    check_eq("top_enable",    64'(bus_a.cpu_enable),    64'd1);

    // Unmapped write: no strobe, data 0, registered error pulse
    bus_a.cpu_addr = 8'hBF; bus_a.cpu_write_en = 1'b1;
    #1;
    check_eq("um_region_en", 64'(bus_a.region_enable),   64'd0);
    check_eq("um_write_en",  64'(bus_a.region_write_en), 64'd0);
    check_eq("um_data",      64'(bus_a.cpu_data_in),     64'd0);
    check_eq("um_addr",      64'(bus_a.region_addr),     64'hBF);
    check_eq("um_enable",    64'(bus_a.cpu_enable),      64'd1);
    check_eq("um_err_early", 64'(bus_a.bus_error),       64'd0);
    tick();
    check_eq("um_err_pulse", 64'(bus_a.bus_error),       64'd1);
    check_eq("um_err_flag",  64'(bus_a.bus_error_flag),  64'd1);
    bus_a.cpu_addr = 8'hEB; bus_a.cpu_write_en = 1'b0;
    #1;
    check_eq("edge_last_r1", 64'(bus_a.region_enable),   64'h2);
    check_eq("edge_last_ad", 64'(bus_a.region_addr),     64'h2B);
    tick();
    check_eq("um_err_drop",  64'(bus_a.bus_error),       64'd0);
    bus_a.cpu_addr = 8'hEC;
    tick();
    check_eq("edge_gap_en",  64'(bus_a.region_enable),   64'd0);
    tick();
    check_eq("gap_err",      64'(bus_a.bus_error),       64'd1);
    bus_a.cpu_addr = 8'h10;
    repeat (2) tick();
    check_eq("flag_sticky",  64'(bus_a.bus_error_flag),  64'd1);
    check_eq("err_cleared",  64'(bus_a.bus_error),       64'd0);

    // Overlap: lowest index wins, size 0 disables region2
    bus_c.cpu_addr = 8'hFF;
    #1;
    check_eq("ov_region_en", 64'(bus_c.region_enable), 64'h1);
    check_eq("ov_addr",      64'(bus_c.region_addr),   64'h0F);
    check_eq("ov_data",      64'(bus_c.cpu_data_in),   64'h44);
    bus_c.cpu_addr = 8'hF8;
    #1;
    check_eq("ov_f8_addr",   64'(bus_c.region_addr),   64'h08);
    bus_c.cpu_addr = 8'hEF;
    #1;
    check_eq("ov_disabled",  64'(bus_c.region_enable), 64'd0);

    // Three-wait write to region1: single strobe in ACK
    bus_b.cpu_addr = 8'hC4; bus_b.cpu_data_out = 8'h5A; bus_b.cpu_write_en = 1'b1;
    #1;
    stall = 0;
    wr_pulses = 0;
    while (!bus_b.cpu_enable && stall < 20) begin
      if (bus_b.region_write_en != 3'b000) wr_pulses++;
      tick();
      stall++;
    end
    check_eq("ww_stall",     64'(stall),                 64'd3);
    check_eq("ww_strobe",    64'(bus_b.region_write_en), 64'h2);
    check_eq("ww_addr",      64'(bus_b.region_addr),     64'h04);
    check_eq("ww_data",      64'(bus_b.region_data_out), 64'h5A);
    if (bus_b.region_write_en != 3'b000) wr_pulses++;
    bus_b.cpu_addr = 8'h00; bus_b.cpu_write_en = 1'b0;
    repeat (2) begin
      tick();
      if (bus_b.region_write_en != 3'b000) wr_pulses++;
    end
    check_eq("ww_one_pulse", 64'(wr_pulses), 64'd1);

    // Reset during the second WAIT cycle abandons the write
    bus_b.cpu_addr = 8'hC4; bus_b.cpu_write_en = 1'b1;
    #1;
    wr_pulses = 0;
    if (bus_b.region_write_en != 3'b000) wr_pulses++;
    tick();
    if (bus_b.region_write_en != 3'b000) wr_pulses++;
    tick();
    if (bus_b.region_write_en != 3'b000) wr_pulses++;
    check_eq("mw_stalled",   64'(bus_b.cpu_enable), 64'd0);
    reset_b = 1'b1;
    tick();
    if (bus_b.region_write_en != 3'b000) wr_pulses++;
    check_eq("mw_boot_rst",  64'(bus_b.cpu_reset),     64'd1);
    check_eq("mw_boot_en",   64'(bus_b.cpu_enable),    64'd0);
    check_eq("mw_boot_sel",  64'(bus_b.region_enable), 64'd0);
    tick();
    reset_b = 1'b0;
    n = 0;
    while (bus_b.cpu_reset && n < 50) begin
      if (bus_b.region_write_en != 3'b000) wr_pulses++;
      tick();
      n++;
    end
    check_eq("mw_boot_len",  64'(n),         64'd4);
    check_eq("mw_no_write",  64'(wr_pulses), 64'd0);
    bus_b.cpu_write_en = 1'b0;

    // Reset clears the sticky error flag
    reset = 1'b1;
    tick();
    check_eq("flag_reset",   64'(bus_a.bus_error_flag), 64'd0);
    check_eq("err_reset",    64'(bus_a.bus_error),      64'd0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reflet_mem_map_ctrl.md
Name: reflet_mem_map_ctrl

Overview:
- Parametrised memory-map controller for Reflet microcontroller tops. Sits between the reflet_cpu bus and N memory/peripheral regions.
- Decodes the CPU address into N regions, each with its own base, size and wait-state count. Forwards region-local addresses and strobes, and muxes read data back to the CPU.
- Stalls the CPU through its enable input during wait states, generates the post-reset CPU boot hold, and flags accesses to unmapped addresses.

Parameters:
- wordsize, 8, bus/address width in bits (8, 16, 32, 64).
- region_count, 3, number of regions N (1..8).
- region_base, {N x wordsize} packed, base address of region i in bits [i*wordsize +: wordsize].
- region_size, {N x wordsize} packed, number of addresses in region i; 0 disables the region.
- region_wait, {N x 4} packed, wait states of region i (0..15).
- boot_cycles, 16, clk cycles cpu_reset is held after reset falls (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  wordsize  CPU address.
- cpu_data_out  in  wordsize  CPU write data.
- cpu_write_en  in  1  CPU write strobe.
- cpu_data_in  out  wordsize  read data to CPU.
- cpu_enable  out  1  CPU enable; low stalls the CPU.
- cpu_reset  out  1  active-high CPU reset; adapter inverts if the CPU needs it.
- region_enable  out  N  one-hot region select.
- region_addr  out  wordsize  cpu_addr minus hit region base.
- region_write_en  out  N  per-region write strobe.
- region_data_out  out  wordsize  write data, equal to cpu_data_out.
- region_data_in  in  N*wordsize  packed region read data; region i at [i*wordsize +: wordsize].
- bus_error  out  1  one-cycle pulse per unmapped access.
- bus_error_flag  out  1  sticky; set by bus_error, cleared only by reset.

Behaviour:
- Reset (reset=1 on a clk edge):
  - FSM goes to BOOT and the boot counter loads boot_cycles.
  - cpu_reset=1, cpu_enable=0, region_enable=0, region_write_en=0, bus_error=0, bus_error_flag=0, cpu_data_in=0.
- Decode (combinational):
  - Region i hits when region_size[i]!=0 and region_base[i] <= cpu_addr < region_base[i]+region_size[i].
  - The sum is computed at wordsize+1 bits, so a region may end exactly at the top of the address space.
  - On overlap, the lowest index wins; region_enable stays one-hot.
  - region_addr = cpu_addr - base of the winning region; it is cpu_addr when nothing hits.
- FSM states: BOOT, IDLE, WAIT, ACK.
  - BOOT: cpu_reset=1, cpu_enable=0. Counter decrements each cycle. Counter==1 leads to IDLE, so cpu_reset is high for exactly boot_cycles cycles after reset falls.
  - IDLE: region_enable reflects the decode.
    - Hit region with wait 0: cpu_enable=1, and the FSM stays in IDLE.
    - Hit region with wait w>0: cpu_enable=0, counter loads w-1, and the FSM goes to WAIT if w>1, else ACK.
    - No hit: cpu_enable=1, cpu_data_in=0, and bus_error pulses on the next cycle (registered).
  - WAIT: cpu_enable=0, region_enable held. Counter decrements; counter==1 leads to ACK (counter==0 on entry is impossible).
  - ACK: cpu_enable=1 for one cycle, then IDLE. IDLE re-decodes whatever address is present, including a repeat of the same address.
  - Total stall is exactly w cycles per access.
- Write strobe:
  - region_write_en[i] = cpu_write_en & region_enable[i] & cpu_enable.
  - A waited write therefore strobes exactly once, in the ACK cycle, which keeps UART/FIFO side effects single.
  - No write strobe is issued for an unmapped address.
- Read data:
  - cpu_data_in is a combinational mux of region_data_in by the winning index, and is 0 when nothing hits or the FSM is in BOOT.
  - A region with synchronous read latency 1 must be given wait>=1.
- cpu_enable is forced to 0 while the FSM is in BOOT.
- Reset mid-WAIT or mid-ACK: the access is abandoned, no write strobe is issued, and the FSM enters BOOT.
- bus_error_flag sets on the same edge as bus_error.

Decomposition:
- Package reflet_mem_map_pkg holds:
  - the FSM state encoding (BOOT/IDLE/WAIT/ACK);
  - the max_regions=8 constant;
  - field-extraction functions for region_base, region_size and region_wait.
- One sub-module: reflet_region_decoder (combinational hit vector, priority one-hot, winning index, local address). It is reused by future bus bridges.

Test Plan:
- Boot hold: wordsize=8, boot_cycles=4; release reset → cpu_reset=1 for exactly 4 cycles, then 0; cpu_enable rises the same cycle cpu_reset falls.
- Zero-wait read: regions {0x00/0x80 w0, 0xC0/0x2C w1, 0xED/0x13 w0}; cpu_addr=0x10 with region0 data 0xA5 → region_enable=001, region_addr=0x10, cpu_data_in=0xA5, cpu_enable never drops.
- Waited write: region1 wait set to 3; write 0x5A to 0xC4 → cpu_enable low for exactly 3 cycles; region_write_en[1] high exactly once (ACK cycle); region_addr=0x04.
- Unmapped: cpu_addr=0xBF read → cpu_data_in=0, no region enable, bus_error pulses once the next cycle, bus_error_flag stays 1 until reset.
- Overlap and top edge: region0 0xF0/0x10, region1 0xF8/0x08; cpu_addr=0xFF → region0 wins with region_addr=0x0F (end sum 0x100 handled).
- Reset mid-WAIT: assert reset during the 2nd wait cycle of a write → no region_write_en pulse; FSM in BOOT; cpu_reset=1 for boot_cycles after release.
